// File: rtl/cam_capture_ctrl.sv
// Camera byte stream -> frame-buffer pixel writes, frame sync pulses and region snapshot; REGION_FILTER_EN adds frame-persistence filter on region_out.
// Latency: 2 pclk from raw input edge to we/frame_start/frame_done; region_out/frame_cnt one cycle after frame_done.
// Backpressure: none, the camera cannot be stalled; pixels past W*H are dropped and flagged.
module cam_capture_ctrl #(
    parameter int W       = 320,
    parameter int H       = 240,
    parameter int PERSIST = 3
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  cam_d,
    input  logic [8:0]  region_in,
    output logic        we,
    output logic [16:0] wAddr,
    output logic [15:0] wData,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_err,
    output logic [8:0]  region_out,
    output logic [15:0] frame_cnt
);

    localparam logic [16:0] NPIX = 17'(W * H);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        vsync_q;
    logic        vsync_p;
    logic        href_q;
    logic [7:0]  d_q;

    logic        vsync_rise;
    logic        vsync_fall;
    logic        fs_evt;
    logic        fe_evt;
    logic        cap_en;

    logic        phase;
    logic [7:0]  hi_byte;
    logic [16:0] pix_cnt;
    logic        ovf;
    logic        done_ok;
    logic        complete;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            vsync_p <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= 8'd0;
        end else begin
            vsync_q <= vsync;
            vsync_p <= vsync_q;
            href_q  <= href;
            d_q     <= cam_d;
        end
    end

    assign vsync_rise = vsync_q & ~vsync_p;
    assign vsync_fall = ~vsync_q & vsync_p;
    assign complete   = (pix_cnt == NPIX) && !ovf;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fs_evt    = 1'b0;
        fe_evt    = 1'b0;
        cap_en    = 1'b0;
        case (state)
            SYNC: begin
                if (vsync_q) begin
                    state_nxt = BLANK;
                end
            end
            BLANK: begin
                if (vsync_fall) begin
                    fs_evt    = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    fe_evt    = 1'b1;
                    state_nxt = BLANK;
                end else begin
                    cap_en = 1'b1;
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // pix_cnt doubles as the write address; it saturates at NPIX so wAddr holds at NPIX-1
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            we          <= 1'b0;
            wAddr       <= 17'd0;
            wData       <= 16'd0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            done_ok     <= 1'b0;
            phase       <= 1'b0;
            hi_byte     <= 8'd0;
            pix_cnt     <= 17'd0;
            ovf         <= 1'b0;
        end else begin
            we          <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            done_ok     <= 1'b0;
            if (fs_evt) begin
                frame_start <= 1'b1;
                pix_cnt     <= 17'd0;
                phase       <= 1'b0;
                ovf         <= 1'b0;
            end else if (fe_evt) begin
                frame_done <= 1'b1;
                frame_err  <= !complete;
                done_ok    <= complete;
                phase      <= 1'b0;
            end else if (cap_en) begin
                if (href_q) begin
                    if (!phase) begin
                        hi_byte <= d_q;
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (pix_cnt < NPIX) begin
                            we      <= 1'b1;
                            wAddr   <= pix_cnt;
                            wData   <= {hi_byte, d_q};
                            pix_cnt <= pix_cnt + 17'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end else begin
                    phase <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 16'd0;
        end else if (done_ok) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // region_in is sampled during the frame_done cycle, before the next frame_start clears the detector
`ifdef REGION_FILTER_EN
    localparam logic [3:0] PERSIST_M1 = 4'(PERSIST - 1);

    logic [3:0] flt_cnt [9];

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            region_out <= 9'd0;
            for (int k = 0; k < 9; k++) begin
                flt_cnt[k] <= 4'd0;
            end
        end else if (done_ok) begin
            for (int k = 0; k < 9; k++) begin
                if (region_in[k] == region_out[k]) begin
                    flt_cnt[k] <= 4'd0;
                end else if (flt_cnt[k] == PERSIST_M1) begin
                    region_out[k] <= ~region_out[k];
                    flt_cnt[k]    <= 4'd0;
                end else begin
                    flt_cnt[k] <= flt_cnt[k] + 4'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            region_out <= 9'd0;
        end else if (done_ok) begin
            region_out <= region_in;
        end
    end
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl on a reduced 8x2 frame: frame-level vector table plus hand-timed latency and reset sequences.
module tb_cam_capture_ctrl;

    localparam int W       = 8;
    localparam int H       = 2;
    localparam int PERSIST = 3;
    localparam int NPIX    = W * H;

    logic        pclk    = 1'b0;
    logic        reset_n = 1'b1;
    logic        vsync   = 1'b0;
    logic        href    = 1'b0;
    logic [7:0]  cam_d   = 8'd0;
    logic [8:0]  region_in = 9'd0;
    logic        we;
    logic [16:0] wAddr;
    logic [15:0] wData;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic [8:0]  region_out;
    logic [15:0] frame_cnt;

    cam_capture_ctrl #(.W(W), .H(H), .PERSIST(PERSIST)) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .vsync       (vsync),
        .href        (href),
        .cam_d       (cam_d),
        .region_in   (region_in),
        .we          (we),
        .wAddr       (wAddr),
        .wData       (wData),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .region_out  (region_out),
        .frame_cnt   (frame_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          npix;
        logic [15:0] base;
        int          tail;
        logic [8:0]  rin;
        logic        exp_err;
        logic [15:0] exp_cnt;
        logic [8:0]  exp_flt;
        logic [8:0]  exp_raw;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          n_fs = 0;
    int          n_fd = 0;
    logic        last_err = 1'b0;
    logic [32:0] exp_q [$];
    logic [32:0] exp_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (frame_start) n_fs++;
        if (frame_done) begin
            n_fd++;
            last_err = frame_err;
        end
        if (we) begin
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 32'(we), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wAddr", 32'(wAddr), 32'(exp_e[32:16]));
                chk("wData", 32'(wData), 32'(exp_e[15:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        href  = 1'b1;
        cam_d = b;
        tick();
    endtask

    // Starts with vsync high; ends with vsync high after frame_done and the region update.
    task automatic run_frame(input int npix, input logic [15:0] base, input int tail, input logic [8:0] rin);
        logic [15:0] px;
        vsync = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < npix; i++) begin
            px = base + 16'(i);
            if (i < NPIX) exp_q.push_back({17'(i), px});
            send_byte(px[15:8]);
            send_byte(px[7:0]);
            if (i == npix - 1 && tail == 2) begin
                send_byte(8'h99);
            end else if ((i + 1) % W == 0 || i == npix - 1) begin
                if (tail == 1 && i + 1 == W) send_byte(8'h77);
                href = 1'b0;
                tick();
                tick();
            end
        end
        region_in = rin;
        vsync = 1'b1;
        tick();
        href = 1'b0;
        repeat (4) tick();
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int fs0;
        int fd0;
        fs0 = n_fs;
        fd0 = n_fd;
        run_frame(v.npix, v.base, v.tail, v.rin);
        chk({tag, "_frame_start_cnt"}, 32'(n_fs - fs0), 32'd1);
        chk({tag, "_frame_done_cnt"}, 32'(n_fd - fd0), 32'd1);
        chk({tag, "_frame_err"}, 32'(last_err), 32'(v.exp_err));
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(v.exp_cnt));
`ifdef REGION_FILTER_EN
        chk({tag, "_region_out"}, 32'(region_out), 32'(v.exp_flt));
`else
        chk({tag, "_region_out"}, 32'(region_out), 32'(v.exp_raw));
`endif
        chk({tag, "_writes_missing"}, 32'(exp_q.size()), 32'd0);
        if (v.npix > NPIX) chk({tag, "_wAddr_hold"}, 32'(wAddr), 32'(NPIX - 1));
        repeat (2) tick();
    endtask

    vec_t vecs [9];
    vec_t post_rst;
    int   fd_mark;

    initial begin
        //             npix base      tail rin     err   cnt     flt     raw
        vecs[0] = '{16, 16'hF800, 0, 9'h001, 1'b0, 16'd1, 9'h000, 9'h001};
        vecs[1] = '{16, 16'h1200, 1, 9'h001, 1'b0, 16'd2, 9'h000, 9'h001};
        vecs[2] = '{16, 16'h2300, 0, 9'h000, 1'b0, 16'd3, 9'h000, 9'h000};
        vecs[3] = '{16, 16'h3400, 2, 9'h001, 1'b0, 16'd4, 9'h000, 9'h001};
        vecs[4] = '{16, 16'h4500, 0, 9'h001, 1'b0, 16'd5, 9'h000, 9'h001};
        vecs[5] = '{16, 16'h5600, 0, 9'h001, 1'b0, 16'd6, 9'h001, 9'h001};
        vecs[6] = '{20, 16'h6700, 0, 9'h1FE, 1'b1, 16'd6, 9'h001, 9'h001};
        vecs[7] = '{10, 16'h7800, 0, 9'h1FE, 1'b1, 16'd6, 9'h001, 9'h001};
        vecs[8] = '{16, 16'h8900, 0, 9'h155, 1'b0, 16'd7, 9'h001, 9'h155};
        post_rst = '{16, 16'h9A00, 0, 9'h0F0, 1'b0, 16'd1, 9'h000, 9'h0F0};

        #2 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wAddr", 32'(wAddr), 32'd0);
        chk("rst_wData", 32'(wData), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_region_out", 32'(region_out), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        reset_n = 1'b1;
        tick();
        vsync = 1'b1;
        repeat (3) tick();

        // frame_start: registered 1 cycle after the edge that samples vsync low
        vsync = 1'b0;
        tick();
        chk("fs_early", 32'(frame_start), 32'd0);
        tick();
        chk("fs_pulse", 32'(frame_start), 32'd1);
        tick();
        chk("fs_one_cycle", 32'(frame_start), 32'd0);

        exp_q.push_back({17'd0, 16'hABCD});
        send_byte(8'hAB);
        send_byte(8'hCD);
        chk("we_early", 32'(we), 32'd0);
        href = 1'b0;
        tick();
        chk("we_pulse", 32'(we), 32'd1);
        chk("we_addr0", 32'(wAddr), 32'd0);
        chk("we_abcd", 32'(wData), 32'h0000ABCD);
        tick();
        chk("we_one_cycle", 32'(we), 32'd0);

        region_in = 9'h1AA;
        vsync = 1'b1;
        tick();
        chk("fd_early", 32'(frame_done), 32'd0);
        tick();
        chk("fd_pulse", 32'(frame_done), 32'd1);
        chk("fd_err_short", 32'(frame_err), 32'd1);
        tick();
        chk("fd_one_cycle", 32'(frame_done), 32'd0);
        chk("short_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("short_region_out", 32'(region_out), 32'd0);
        repeat (2) tick();

        for (int i = 0; i < 9; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of an active frame
        vsync = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({17'(i), 16'hC000 + 16'(i)});
            send_byte(8'hC0);
            send_byte(8'(i));
        end
        href = 1'b0;
        repeat (2) tick();
        send_byte(8'h11);
        cam_d = 8'h22;
        reset_n = 1'b0;
        tick();
        chk("rst2_we", 32'(we), 32'd0);
        chk("rst2_wAddr", 32'(wAddr), 32'd0);
        chk("rst2_wData", 32'(wData), 32'd0);
        chk("rst2_frame_done", 32'(frame_done), 32'd0);
        chk("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst2_region_out", 32'(region_out), 32'd0);
        fd_mark = n_fd;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i));
        href = 1'b0;
        tick();
        vsync = 1'b1;
        repeat (4) tick();
        chk("rst2_no_done", 32'(n_fd - fd_mark), 32'd0);
        chk("rst2_no_writes", 32'(exp_q.size()), 32'd0);
        apply_vec("post_rst", post_rst);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
